// File: rtl/trap_ctrl_pkg.sv
// Shared trap constants, FSM state type and target-PC helper for trap_ctrl.
package trap_ctrl_pkg;

  localparam logic [3:0] EXC_IMISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL   = 4'd2;
  localparam logic [3:0] EXC_BREAK     = 4'd3;
  localparam logic [3:0] EXC_LMISALIGN = 4'd4;
  localparam logic [3:0] EXC_SMISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M   = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int unsigned MSTATUS_MIE = 3;
  localparam int unsigned MIE_MSIE    = 3;
  localparam int unsigned MIE_MTIE    = 7;
  localparam int unsigned MIE_MEIE    = 11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlush    = 2'd1,
    StRedirect = 2'd2
  } trap_state_e;

  // Only interrupts taken in vectored mode are offset; everything else lands on base.
  function automatic logic [31:0] trap_target(input logic [31:0] base,
                                              input logic [1:0]  mode,
                                              input logic        is_irq,
                                              input logic [3:0]  code);
    logic [31:0] vec;
    vec = {base[31:2], 2'b00} + {26'h0, code, 2'b00};
    return (mode == MTVEC_VECTORED && is_irq) ? vec : base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI.
module trap_irq_prio
  import trap_ctrl_pkg::*;
(
  input  logic       pend_ext,
  input  logic       pend_sw,
  input  logic       pend_tmr,
  output logic       irq_any,
  output logic [3:0] irq_code
);

  always_comb begin
    irq_any  = pend_ext | pend_sw | pend_tmr;
    irq_code = 4'd0;
    if (pend_ext) begin
      irq_code = IRQ_MEI;
    end else if (pend_sw) begin
      irq_code = IRQ_MSI;
    end else if (pend_tmr) begin
      irq_code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-point trap sequencer: picks exception/interrupt/MRET, pulses csr_unit,
// flushes the pipeline and then holds a redirect to fetch until accepted.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        irq_tmr,
  input  logic        irq_sw,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_base_i,
  input  logic [1:0]  mtvec_mode_i,
  input  logic [31:0] mepc_i,
  input  logic        fetch_ready,
  output logic        trap_taken,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_tval,
  output logic        mret_exec,
  output logic        kill_commit,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

  trap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic       pend_ext, pend_sw, pend_tmr;
  logic       irq_any;
  logic [3:0] irq_code;
  logic       take_exc, take_irq, take_mret;

  assign pend_ext = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MEIE] & irq_ext;
  assign pend_sw  = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MSIE] & irq_sw;
  assign pend_tmr = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MTIE] & irq_tmr;

  trap_irq_prio u_irq_prio (
    .pend_ext (pend_ext),
    .pend_sw  (pend_sw),
    .pend_tmr (pend_tmr),
    .irq_any  (irq_any),
    .irq_code (irq_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    take_exc       = 1'b0;
    take_irq       = 1'b0;
    take_mret      = 1'b0;
    trap_taken     = 1'b0;
    trap_pc        = 32'h0;
    trap_cause     = 32'h0;
    trap_tval      = 32'h0;
    mret_exec      = 1'b0;
    kill_commit    = 1'b0;
    flush_o        = 1'b0;
    stall_o        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so every output reads zero while reset is held.
        if (commit_valid && !rst) begin
          take_exc  = exc_valid;
          take_irq  = !exc_valid && irq_any;
          take_mret = !exc_valid && !irq_any && mret_req;
        end
        if (take_exc) begin
          trap_taken  = 1'b1;
          trap_pc     = commit_pc;
          trap_cause  = {28'h0, exc_code};
          trap_tval   = exc_tval;
          kill_commit = 1'b1;
          target_d    = trap_target(mtvec_base_i, mtvec_mode_i, 1'b0, exc_code);
        end else if (take_irq) begin
          trap_taken  = 1'b1;
          trap_pc     = commit_pc;
          trap_cause  = {1'b1, 27'h0, irq_code};
          kill_commit = 1'b1;
          target_d    = trap_target(mtvec_base_i, mtvec_mode_i, 1'b1, irq_code);
        end else if (take_mret) begin
          mret_exec = 1'b1;
          target_d  = mepc_i;
        end
        if (take_exc || take_irq || take_mret) begin
          cnt_d   = 4'd0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
        if (cnt_q >= FlushLast) begin
          cnt_d   = 4'd0;
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRedirect: begin
        stall_o        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (fetch_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = ^{mstatus_i[31:4], mstatus_i[2:0], mie_i[31:12], mie_i[10:8],
                           mie_i[6:4], mie_i[2:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic        mret_req;
  logic        irq_ext, irq_tmr, irq_sw;
  logic [31:0] mstatus_i, mie_i, mtvec_base_i, mepc_i;
  logic [1:0]  mtvec_mode_i;
  logic        fetch_ready;
  logic        trap_taken, mret_exec, kill_commit, flush_o, stall_o, redirect_valid;
  logic [31:0] trap_pc, trap_cause, trap_tval, redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_tval       (exc_tval),
    .mret_req       (mret_req),
    .irq_ext        (irq_ext),
    .irq_tmr        (irq_tmr),
    .irq_sw         (irq_sw),
    .mstatus_i      (mstatus_i),
    .mie_i          (mie_i),
    .mtvec_base_i   (mtvec_base_i),
    .mtvec_mode_i   (mtvec_mode_i),
    .mepc_i         (mepc_i),
    .fetch_ready    (fetch_ready),
    .trap_taken     (trap_taken),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .mret_exec      (mret_exec),
    .kill_commit    (kill_commit),
    .flush_o        (flush_o),
    .stall_o        (stall_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_events();
    commit_valid = 1'b0;
    exc_valid    = 1'b0;
    mret_req     = 1'b0;
    irq_ext      = 1'b0;
    irq_tmr      = 1'b0;
    irq_sw       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_events();
    commit_pc = 32'h0; exc_code = 4'd0; exc_tval = 32'h0;
    mstatus_i = 32'h0; mie_i = 32'h0; mtvec_base_i = 32'h0; mtvec_mode_i = 2'b00;
    mepc_i = 32'h0; fetch_ready = 1'b0;
    repeat (3) step();
    #1;
    n_tests++;
    if ({trap_taken, mret_exec, kill_commit, flush_o, stall_o, redirect_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {trap_taken, mret_exec, kill_commit, flush_o, stall_o, redirect_valid});
    end
    n_tests++;
    if (redirect_pc !== 32'h0 || trap_cause !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got pc=%h cause=%h exp 0/0", redirect_pc, trap_cause);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_exception();
    step();
    commit_valid = 1'b1; commit_pc = 32'h100; exc_valid = 1'b1; exc_code = 4'd2;
    exc_tval = 32'hDEAD; mtvec_base_i = 32'h800; mtvec_mode_i = 2'b01; fetch_ready = 1'b0;
    #1;
    n_tests++;
    if (trap_taken !== 1'b1 || kill_commit !== 1'b1 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_pulse got taken=%b kill=%b stall=%b exp 1/1/0",
               trap_taken, kill_commit, stall_o);
    end
    n_tests++;
    if (trap_cause !== 32'h2 || trap_pc !== 32'h100 || trap_tval !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL exc_data got cause=%h pc=%h tval=%h exp 2/100/dead",
               trap_cause, trap_pc, trap_tval);
    end
    step(); clear_events(); #1;
    n_tests++;
    if (flush_o !== 1'b1 || stall_o !== 1'b1 || trap_taken !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_flush1 got flush=%b stall=%b taken=%b rv=%b exp 1/1/0/0",
               flush_o, stall_o, trap_taken, redirect_valid);
    end
    step(); #1;
    n_tests++;
    if (flush_o !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_flush2 got flush=%b rv=%b exp 1/0", flush_o, redirect_valid);
    end
    step(); #1;
    n_tests++;
    if (flush_o !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h800 || stall_o !== 1'b1)
    begin
      n_fail++;
      $display("FAIL exc_redirect got flush=%b rv=%b pc=%h stall=%b exp 0/1/800/1",
               flush_o, redirect_valid, redirect_pc, stall_o);
    end
    step(); #1;
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h800) begin
      n_fail++;
      $display("FAIL exc_hold got rv=%b pc=%h exp 1/800", redirect_valid, redirect_pc);
    end
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0; #1;
    n_tests++;
    if (redirect_valid !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_idle got rv=%b stall=%b flush=%b exp 0/0/0",
               redirect_valid, stall_o, flush_o);
    end
  endtask

  task automatic test_irq_timer();
    step();
    commit_valid = 1'b1; commit_pc = 32'h204; irq_tmr = 1'b1;
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_base_i = 32'h800; mtvec_mode_i = 2'b01;
    #1;
    n_tests++;
    if (trap_taken !== 1'b1 || trap_cause !== 32'h8000_0007 || trap_pc !== 32'h204 ||
        trap_tval !== 32'h0 || kill_commit !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_tmr got taken=%b cause=%h pc=%h tval=%h kill=%b exp 1/80000007/204/0/1",
               trap_taken, trap_cause, trap_pc, trap_tval, kill_commit);
    end
    step(); clear_events();
    step(); step(); #1;
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h81C) begin
      n_fail++;
      $display("FAIL irq_vec_target got rv=%b pc=%h exp 1/81c", redirect_valid, redirect_pc);
    end
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0;
    commit_valid = 1'b1; irq_tmr = 1'b1; mstatus_i = 32'h0; #1;
    n_tests++;
    if (trap_taken !== 1'b0 || kill_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked got taken=%b kill=%b exp 0/0", trap_taken, kill_commit);
    end
    step(); #1;
    n_tests++;
    if (stall_o !== 1'b0 || flush_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked_state got stall=%b flush=%b exp 0/0", stall_o, flush_o);
    end
    clear_events();
  endtask

  task automatic test_priority();
    step();
    commit_valid = 1'b1; commit_pc = 32'h300; irq_ext = 1'b1; irq_sw = 1'b1; irq_tmr = 1'b1;
    mstatus_i = 32'h8; mie_i = 32'h888; mtvec_base_i = 32'h800; mtvec_mode_i = 2'b01;
    fetch_ready = 1'b1; #1;
    n_tests++;
    if (trap_taken !== 1'b1 || trap_cause !== 32'h8000_000B) begin
      n_fail++;
      $display("FAIL prio_mei got taken=%b cause=%h exp 1/8000000b", trap_taken, trap_cause);
    end
    step(); clear_events();
    step(); step(); #1;
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h82C) begin
      n_fail++;
      $display("FAIL prio_mei_target got rv=%b pc=%h exp 1/82c", redirect_valid, redirect_pc);
    end
    step();
    // MSI outranks MTI
    commit_valid = 1'b1; irq_sw = 1'b1; irq_tmr = 1'b1; #1;
    n_tests++;
    if (trap_cause !== 32'h8000_0003) begin
      n_fail++;
      $display("FAIL prio_msi got cause=%h exp 80000003", trap_cause);
    end
    step(); clear_events(); step(); step(); step();
    commit_valid = 1'b1; irq_ext = 1'b1; irq_sw = 1'b1; irq_tmr = 1'b1;
    exc_valid = 1'b1; exc_code = 4'd11; exc_tval = 32'h0;
    mtvec_base_i = 32'h400; mtvec_mode_i = 2'b00; #1;
    n_tests++;
    if (trap_cause !== 32'h0000_000B || trap_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_exc_over_irq got taken=%b cause=%h exp 1/0000000b", trap_taken, trap_cause);
    end
    step(); clear_events(); step(); step(); #1;
    n_tests++;
    if (redirect_pc !== 32'h400) begin
      n_fail++;
      $display("FAIL prio_direct_target got pc=%h exp 400", redirect_pc);
    end
    step();
    commit_valid = 1'b1; exc_valid = 1'b1; mret_req = 1'b1; exc_code = 4'd3; #1;
    n_tests++;
    if (trap_taken !== 1'b1 || mret_exec !== 1'b0 || trap_cause !== 32'h3) begin
      n_fail++;
      $display("FAIL prio_exc_over_mret got taken=%b mret=%b cause=%h exp 1/0/3",
               trap_taken, mret_exec, trap_cause);
    end
    step(); clear_events(); step(); step(); step();
    fetch_ready = 1'b0;
  endtask

  task automatic test_mret();
    commit_valid = 1'b0; mret_req = 1'b1; #1;
    n_tests++;
    if (mret_exec !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_no_commit got mret=%b stall=%b exp 0/0", mret_exec, stall_o);
    end
    step();
    commit_valid = 1'b1; mret_req = 1'b1; mepc_i = 32'h344; mtvec_base_i = 32'h800; #1;
    n_tests++;
    if (mret_exec !== 1'b1 || trap_taken !== 1'b0 || kill_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_pulse got mret=%b taken=%b kill=%b exp 1/0/0",
               mret_exec, trap_taken, kill_commit);
    end
    step(); clear_events(); #1;
    n_tests++;
    if (mret_exec !== 1'b0 || flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_one_cycle got mret=%b flush=%b exp 0/1", mret_exec, flush_o);
    end
    step(); step(); #1;
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h344) begin
      n_fail++;
      $display("FAIL mret_target got rv=%b pc=%h exp 1/344", redirect_valid, redirect_pc);
    end
    fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    commit_valid = 1'b1; commit_pc = 32'h500; exc_valid = 1'b1; exc_code = 4'd4;
    exc_tval = 32'h1234; mtvec_base_i = 32'h900; mtvec_mode_i = 2'b10;
    step(); clear_events(); step(); step();
    for (int i = 0; i < 5; i++) begin
      commit_valid = 1'b1; exc_valid = (i % 2) == 0; exc_code = 4'd6;
      mtvec_base_i = 32'hA00; #1;
      n_tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h900 || trap_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got rv=%b pc=%h taken=%b exp 1/900/0",
                 i, redirect_valid, redirect_pc, trap_taken);
      end
      step();
    end
    clear_events(); fetch_ready = 1'b1;
    step(); fetch_ready = 1'b0; #1;
    n_tests++;
    if (redirect_valid !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release got rv=%b stall=%b exp 0/0", redirect_valid, stall_o);
    end
  endtask

  task automatic test_reset_mid();
    step();
    commit_valid = 1'b1; commit_pc = 32'h600; exc_valid = 1'b1; exc_code = 4'd0;
    exc_tval = 32'h601; mtvec_base_i = 32'h800; mtvec_mode_i = 2'b00;
    step(); clear_events(); #1;
    n_tests++;
    if (flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre got flush=%b exp 1", flush_o);
    end
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    n_tests++;
    if ({trap_taken, mret_exec, kill_commit, flush_o, stall_o, redirect_valid} !== 6'b0 ||
        redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got %b pc=%h exp 000000/0",
               {trap_taken, mret_exec, kill_commit, flush_o, stall_o, redirect_valid}, redirect_pc);
    end
    step();
    commit_valid = 1'b1; commit_pc = 32'h700; exc_valid = 1'b1; exc_code = 4'd2; #1;
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== 32'h700 || trap_cause !== 32'h2) begin
      n_fail++;
      $display("FAIL rst_mid_retrap got taken=%b pc=%h cause=%h exp 1/700/2",
               trap_taken, trap_pc, trap_cause);
    end
    step(); clear_events(); step(); step(); #1;
    n_tests++;
    if (redirect_pc !== 32'h800) begin
      n_fail++;
      $display("FAIL rst_mid_target got pc=%h exp 800", redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_irq_timer();
    test_priority();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
